// File: rtl/alu_imm_iq_pkg.sv
// Issue-queue helpers: lowest-set-bit priority encoder shared by selectors.
package alu_imm_iq_pkg;

    localparam int unsigned PE_W     = 32;
    localparam int unsigned PE_IDX_W = 5;

    // Index of the lowest set bit of req (0 when req is empty).
    function automatic logic [PE_IDX_W-1:0] pe_lsb(input logic [PE_W-1:0] req);
        logic [PE_IDX_W-1:0] idx;
        idx = '0;
        for (int i = PE_W - 1; i >= 0; i--) begin
            if (req[i]) idx = PE_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/core_types.sv
// Core-wide physical register, ROB and issue-queue entry types.
package core_types;

    localparam int unsigned PR_W           = 7;
    localparam int unsigned PRF_BANK_COUNT = 4;
    localparam int unsigned PR_BANK_W      = 2;
    localparam int unsigned UPPER_PR_W     = PR_W - PR_BANK_W;
    localparam int unsigned ROB_W          = 6;

    typedef logic [PR_W-1:0]       PR_t;
    typedef logic [UPPER_PR_W-1:0] upper_PR_t;
    typedef logic [PR_BANK_W-1:0]  PR_bank_t;
    typedef logic [ROB_W-1:0]      ROB_index_t;

    // Bank is the low PR bits; the upper bits form the writeback tag within a bank.
    function automatic PR_bank_t PR_bank_bits(input PR_t pr);
        return pr[PR_BANK_W-1:0];
    endfunction

    function automatic upper_PR_t upper_PR_bits(input PR_t pr);
        return pr[PR_W-1:PR_BANK_W];
    endfunction

    typedef struct packed {
        logic [3:0]  op;
        logic [11:0] imm12;
        PR_t         A_PR;
        logic        A_ready;
        logic        A_is_zero;
        PR_t         dest_PR;
        ROB_index_t  ROB_index;
    } alu_imm_iq_entry_t;

endpackage

// File: rtl/alu_imm_iq_wakeup.sv
// Writeback-bus tag compare for one operand: high when its bank writes its PR.
module alu_imm_iq_wakeup
    import core_types::*;
(
    input  logic                                valid,
    input  PR_t                                 A_PR,
    input  logic [PRF_BANK_COUNT-1:0]           WB_bus_valid_by_bank,
    input  upper_PR_t [PRF_BANK_COUNT-1:0]      WB_bus_upper_PR_by_bank,
    output logic                                new_A_ready
);

    PR_bank_t bank;

    // Look up the bank this PR lives in and compare its upper tag.
    always_comb begin
        bank        = PR_bank_bits(A_PR);
        new_A_ready = valid & WB_bus_valid_by_bank[bank]
                    & (upper_PR_bits(A_PR) == WB_bus_upper_PR_by_bank[bank]);
    end

endmodule

// File: rtl/alu_imm_iq.sv
// ALU reg-imm issue queue: age-ordered, compacting, operand-A wakeup from WB bus.
// Optional macro ALU_IMM_IQ_OCCUPANCY_EN adds the registered iq_occupancy output.
module alu_imm_iq
    import core_types::*;
    import alu_imm_iq_pkg::*;
#(
    parameter int unsigned ALU_IMM_IQ_ENTRIES = 8
) (
    input  logic                            CLK,
    input  logic                            nRST,
    input  logic                            iq_enq_valid,
    input  logic [3:0]                      iq_enq_op,
    input  logic [11:0]                     iq_enq_imm12,
    input  PR_t                             iq_enq_A_PR,
    input  logic                            iq_enq_A_ready,
    input  logic                            iq_enq_A_is_zero,
    input  PR_t                             iq_enq_dest_PR,
    input  ROB_index_t                      iq_enq_ROB_index,
    output logic                            iq_enq_ready,
    input  logic [PRF_BANK_COUNT-1:0]       WB_bus_valid_by_bank,
    input  upper_PR_t [PRF_BANK_COUNT-1:0]  WB_bus_upper_PR_by_bank,
    output logic                            issue_valid,
    output logic [3:0]                      issue_op,
    output logic [11:0]                     issue_imm12,
    output logic                            issue_A_forward,
    output logic                            issue_A_is_zero,
    output PR_bank_t                        issue_A_bank,
    output PR_t                             issue_dest_PR,
    output ROB_index_t                      issue_ROB_index,
    output logic                            PRF_req_A_valid,
    output PR_t                             PRF_req_A_PR,
    input  logic                            issue_ready
`ifdef ALU_IMM_IQ_OCCUPANCY_EN
    ,
    output logic [$clog2(ALU_IMM_IQ_ENTRIES+1)-1:0] iq_occupancy
`endif
);

    localparam int unsigned E     = ALU_IMM_IQ_ENTRIES;
    localparam int unsigned IDX_W = $clog2(E);
    localparam int unsigned CNT_W = $clog2(E + 1);

    alu_imm_iq_entry_t entry_q [E];
    alu_imm_iq_entry_t entry_d [E];
    logic [E-1:0]      valid_q, valid_d;
    logic [E-1:0]      new_A_ready;
    logic [E-1:0]      ready_vec;
    logic              enq_new_A_ready;
    logic              any_ready, issuing, enq_fire;
    logic [IDX_W-1:0]  sel_idx, enq_idx;
    logic [CNT_W-1:0]  count;
    alu_imm_iq_entry_t sel_entry;
    logic              sel_new;

    // Per-entry wakeup compares against the writeback bus.
    for (genvar g = 0; g < E; g++) begin : g_wake
        alu_imm_iq_wakeup u_wake (
            .valid                   (valid_q[g]),
            .A_PR                    (entry_q[g].A_PR),
            .WB_bus_valid_by_bank    (WB_bus_valid_by_bank),
            .WB_bus_upper_PR_by_bank (WB_bus_upper_PR_by_bank),
            .new_A_ready             (new_A_ready[g])
        );
    end

    // Incoming op can catch a writeback in the same cycle it is enqueued.
    alu_imm_iq_wakeup u_enq_wake (
        .valid                   (1'b1),
        .A_PR                    (iq_enq_A_PR),
        .WB_bus_valid_by_bank    (WB_bus_valid_by_bank),
        .WB_bus_upper_PR_by_bank (WB_bus_upper_PR_by_bank),
        .new_A_ready             (enq_new_A_ready)
    );

    // Ready vector, oldest-ready select, issue outputs and occupancy count.
    always_comb begin
        for (int i = 0; i < int'(E); i++) begin
            ready_vec[i] = valid_q[i] & (entry_q[i].A_ready | entry_q[i].A_is_zero | new_A_ready[i]);
        end
        any_ready = |ready_vec;
        sel_idx   = IDX_W'(pe_lsb(PE_W'(ready_vec)));
        issuing   = any_ready & issue_ready;
        sel_entry = entry_q[sel_idx];
        sel_new   = new_A_ready[sel_idx];

        count = '0;
        for (int i = 0; i < int'(E); i++) begin
            count = count + CNT_W'(valid_q[i]);
        end

        iq_enq_ready = ~valid_q[E-1];
        enq_fire     = iq_enq_valid & iq_enq_ready;
        enq_idx      = IDX_W'(count - CNT_W'(issuing));

        issue_valid     = issuing;
        issue_op        = sel_entry.op;
        issue_imm12     = sel_entry.imm12;
        issue_A_forward = sel_new & ~sel_entry.A_ready & ~sel_entry.A_is_zero;
        issue_A_is_zero = sel_entry.A_is_zero;
        issue_A_bank    = PR_bank_bits(sel_entry.A_PR);
        issue_dest_PR   = sel_entry.dest_PR;
        issue_ROB_index = sel_entry.ROB_index;
        PRF_req_A_valid = issuing & sel_entry.A_ready & ~sel_entry.A_is_zero;
        PRF_req_A_PR    = sel_entry.A_PR;
    end

    // Next queue state: accumulate wakeup, compact above the issued slot, append enqueue.
    always_comb begin
        for (int i = 0; i < int'(E); i++) begin
            entry_d[i]         = entry_q[i];
            entry_d[i].A_ready = entry_q[i].A_ready | new_A_ready[i];
            valid_d[i]         = valid_q[i];
        end
        if (issuing) begin
            for (int i = 0; i < int'(E) - 1; i++) begin
                if (IDX_W'(i) >= sel_idx) begin
                    entry_d[i]         = entry_q[i+1];
                    entry_d[i].A_ready = entry_q[i+1].A_ready | new_A_ready[i+1];
                    valid_d[i]         = valid_q[i+1];
                end
            end
            entry_d[E-1] = '0;
            valid_d[E-1] = 1'b0;
        end
        if (enq_fire) begin
            entry_d[enq_idx].op        = iq_enq_op;
            entry_d[enq_idx].imm12     = iq_enq_imm12;
            entry_d[enq_idx].A_PR      = iq_enq_A_PR;
            entry_d[enq_idx].A_ready   = iq_enq_A_ready | enq_new_A_ready;
            entry_d[enq_idx].A_is_zero = iq_enq_A_is_zero;
            entry_d[enq_idx].dest_PR   = iq_enq_dest_PR;
            entry_d[enq_idx].ROB_index = iq_enq_ROB_index;
            valid_d[enq_idx]           = 1'b1;
        end
    end

    // Queue storage with synchronous clear.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            valid_q <= '0;
            for (int i = 0; i < int'(E); i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            entry_q <= entry_d;
        end
    end

`ifdef ALU_IMM_IQ_OCCUPANCY_EN
    logic [CNT_W-1:0] occ_q, occ_d;

    // Running occupancy: +1 on enqueue, -1 on issue.
    always_comb begin
        occ_d = occ_q + CNT_W'(enq_fire) - CNT_W'(issuing);
    end

    // Occupancy register.
    always_ff @(posedge CLK) begin
        if (!nRST) occ_q <= '0;
        else       occ_q <= occ_d;
    end

    assign iq_occupancy = occ_q;
`endif

endmodule

// File: tb/tb_alu_imm_iq.sv
// Directed self-checking bench for alu_imm_iq (honours ALU_IMM_IQ_OCCUPANCY_EN).
module tb_alu_imm_iq;
    import core_types::*;

    logic                           CLK = 1'b0;
    logic                           nRST;
    logic                           iq_enq_valid;
    logic [3:0]                     iq_enq_op;
    logic [11:0]                    iq_enq_imm12;
    PR_t                            iq_enq_A_PR;
    logic                           iq_enq_A_ready;
    logic                           iq_enq_A_is_zero;
    PR_t                            iq_enq_dest_PR;
    ROB_index_t                     iq_enq_ROB_index;
    logic                           iq_enq_ready;
    logic [PRF_BANK_COUNT-1:0]      WB_bus_valid_by_bank;
    upper_PR_t [PRF_BANK_COUNT-1:0] WB_bus_upper_PR_by_bank;
    logic                           issue_valid;
    logic [3:0]                     issue_op;
    logic [11:0]                    issue_imm12;
    logic                           issue_A_forward;
    logic                           issue_A_is_zero;
    PR_bank_t                       issue_A_bank;
    PR_t                            issue_dest_PR;
    ROB_index_t                     issue_ROB_index;
    logic                           PRF_req_A_valid;
    PR_t                            PRF_req_A_PR;
    logic                           issue_ready;
`ifdef ALU_IMM_IQ_OCCUPANCY_EN
    logic [3:0]                     iq_occupancy;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    alu_imm_iq #(.ALU_IMM_IQ_ENTRIES(8)) dut (
        .CLK                     (CLK),
        .nRST                    (nRST),
        .iq_enq_valid            (iq_enq_valid),
        .iq_enq_op               (iq_enq_op),
        .iq_enq_imm12            (iq_enq_imm12),
        .iq_enq_A_PR             (iq_enq_A_PR),
        .iq_enq_A_ready          (iq_enq_A_ready),
        .iq_enq_A_is_zero        (iq_enq_A_is_zero),
        .iq_enq_dest_PR          (iq_enq_dest_PR),
        .iq_enq_ROB_index        (iq_enq_ROB_index),
        .iq_enq_ready            (iq_enq_ready),
        .WB_bus_valid_by_bank    (WB_bus_valid_by_bank),
        .WB_bus_upper_PR_by_bank (WB_bus_upper_PR_by_bank),
        .issue_valid             (issue_valid),
        .issue_op                (issue_op),
        .issue_imm12             (issue_imm12),
        .issue_A_forward         (issue_A_forward),
        .issue_A_is_zero         (issue_A_is_zero),
        .issue_A_bank            (issue_A_bank),
        .issue_dest_PR           (issue_dest_PR),
        .issue_ROB_index         (issue_ROB_index),
        .PRF_req_A_valid         (PRF_req_A_valid),
        .PRF_req_A_PR            (PRF_req_A_PR),
        .issue_ready             (issue_ready)
`ifdef ALU_IMM_IQ_OCCUPANCY_EN
        ,
        .iq_occupancy            (iq_occupancy)
`endif
    );

    // Inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Outputs are sampled mid-cycle, well away from either edge.
    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        iq_enq_valid            = 1'b0;
        iq_enq_op               = '0;
        iq_enq_imm12            = '0;
        iq_enq_A_PR             = '0;
        iq_enq_A_ready          = 1'b0;
        iq_enq_A_is_zero        = 1'b0;
        iq_enq_dest_PR          = '0;
        iq_enq_ROB_index        = '0;
        WB_bus_valid_by_bank    = '0;
        WB_bus_upper_PR_by_bank = '0;
        issue_ready             = 1'b1;
    endtask

    task automatic drive_enq(input logic [3:0] op, input logic [11:0] imm, input PR_t a_pr,
                             input logic a_rdy, input logic a_zero, input PR_t dst, input ROB_index_t rob);
        iq_enq_valid     = 1'b1;
        iq_enq_op        = op;
        iq_enq_imm12     = imm;
        iq_enq_A_PR      = a_pr;
        iq_enq_A_ready   = a_rdy;
        iq_enq_A_is_zero = a_zero;
        iq_enq_dest_PR   = dst;
        iq_enq_ROB_index = rob;
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 1'b0;
        step();
        step();
        nRST = 1'b1;
        settle();
        checks++; if (iq_enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready: got %0b exp 1", iq_enq_ready); end
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %0b exp 0", issue_valid); end
        checks++; if (PRF_req_A_valid !== 1'b0) begin errors++; $display("FAIL reset_prf_valid: got %0b exp 0", PRF_req_A_valid); end
        checks++; if (issue_A_forward !== 1'b0) begin errors++; $display("FAIL reset_forward: got %0b exp 0", issue_A_forward); end
        checks++; if (issue_ROB_index !== 6'd0) begin errors++; $display("FAIL reset_rob: got %0d exp 0", issue_ROB_index); end
`ifdef ALU_IMM_IQ_OCCUPANCY_EN
        checks++; if (iq_occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ: got %0d exp 0", iq_occupancy); end
`endif
    endtask

    task automatic test_prf_issue();
        step();
        drive_enq(4'h2, 12'h0FF, 7'h10, 1'b1, 1'b0, 7'h20, 6'd5);
        settle();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL prf_same_cycle: got %0b exp 0", issue_valid); end
        step();
        idle_inputs();
        settle();
        checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL prf_valid: got %0b exp 1", issue_valid); end
        checks++; if (PRF_req_A_valid !== 1'b1) begin errors++; $display("FAIL prf_req: got %0b exp 1", PRF_req_A_valid); end
        checks++; if (PRF_req_A_PR !== 7'h10) begin errors++; $display("FAIL prf_pr: got %h exp 10", PRF_req_A_PR); end
        checks++; if (issue_A_forward !== 1'b0) begin errors++; $display("FAIL prf_forward: got %0b exp 0", issue_A_forward); end
        checks++; if (issue_op !== 4'h2 || issue_imm12 !== 12'h0FF) begin errors++; $display("FAIL prf_fields: got op %h imm %h exp 2 0ff", issue_op, issue_imm12); end
        checks++; if (issue_dest_PR !== 7'h20 || issue_ROB_index !== 6'd5) begin errors++; $display("FAIL prf_dest: got %h/%0d exp 20/5", issue_dest_PR, issue_ROB_index); end
        step();
        settle();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL prf_empty: got %0b exp 0", issue_valid); end
    endtask

    // A_PR 0x05 = bank 1, upper tag 1.
    task automatic test_forward();
        drive_enq(4'h3, 12'h123, 7'h05, 1'b0, 1'b0, 7'h21, 6'd9);
        step();
        idle_inputs();
        WB_bus_valid_by_bank       = 4'b0010;
        WB_bus_upper_PR_by_bank[1] = 5'd2;
        settle();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL fwd_wrong_tag: got %0b exp 0", issue_valid); end
        step();
        WB_bus_upper_PR_by_bank[1] = 5'd1;
        settle();
        checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL fwd_valid: got %0b exp 1", issue_valid); end
        checks++; if (issue_A_forward !== 1'b1) begin errors++; $display("FAIL fwd_forward: got %0b exp 1", issue_A_forward); end
        checks++; if (issue_A_bank !== 2'd1) begin errors++; $display("FAIL fwd_bank: got %0d exp 1", issue_A_bank); end
        checks++; if (PRF_req_A_valid !== 1'b0) begin errors++; $display("FAIL fwd_prf: got %0b exp 0", PRF_req_A_valid); end
        checks++; if (issue_ROB_index !== 6'd9) begin errors++; $display("FAIL fwd_rob: got %0d exp 9", issue_ROB_index); end
        step();
        idle_inputs();
        settle();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL fwd_empty: got %0b exp 0", issue_valid); end
    endtask

    // Entry i uses bank 2, upper tag 8+i.
    task automatic test_fill();
        int exp_rob [7];
        exp_rob = '{0, 1, 2, 4, 5, 6, 7};
        for (int i = 0; i < 8; i++) begin
            drive_enq(4'h1, 12'(i), 7'((8 + i) * 4 + 2), 1'b0, 1'b0, 7'(i), 6'(i));
            step();
        end
        idle_inputs();
        settle();
        checks++; if (iq_enq_ready !== 1'b0) begin errors++; $display("FAIL fill_full: got %0b exp 0", iq_enq_ready); end
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL fill_no_issue: got %0b exp 0", issue_valid); end
`ifdef ALU_IMM_IQ_OCCUPANCY_EN
        checks++; if (iq_occupancy !== 4'd8) begin errors++; $display("FAIL fill_occ: got %0d exp 8", iq_occupancy); end
`endif
        drive_enq(4'h1, 12'h0, 7'h7F, 1'b1, 1'b0, 7'h0, 6'd15);
        WB_bus_valid_by_bank       = 4'b0100;
        WB_bus_upper_PR_by_bank[2] = 5'd11;
        settle();
        checks++; if (issue_valid !== 1'b1 || issue_ROB_index !== 6'd3) begin errors++; $display("FAIL fill_wake3: got v%0b rob %0d exp v1 rob 3", issue_valid, issue_ROB_index); end
        step();
        idle_inputs();
        issue_ready = 1'b0;
        settle();
        checks++; if (iq_enq_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_after: got %0b exp 1", iq_enq_ready); end
        // Wake the remaining entries newest-first while stalled; they must drain in age order.
        for (int k = 6; k >= 0; k--) begin
            WB_bus_valid_by_bank       = 4'b0100;
            WB_bus_upper_PR_by_bank[2] = 5'(8 + exp_rob[k]);
            step();
        end
        idle_inputs();
        for (int k = 0; k < 7; k++) begin
            settle();
            checks++; if (issue_valid !== 1'b1 || issue_ROB_index !== 6'(exp_rob[k])) begin errors++; $display("FAIL fill_order%0d: got v%0b rob %0d exp v1 rob %0d", k, issue_valid, issue_ROB_index, exp_rob[k]); end
            step();
        end
        settle();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL fill_drained: got %0b exp 0", issue_valid); end
        step();
    endtask

    task automatic test_stall();
        issue_ready = 1'b0;
        drive_enq(4'h4, 12'h001, 7'h11, 1'b1, 1'b0, 7'h30, 6'd20);
        step();
        drive_enq(4'h4, 12'h002, 7'(20 * 4 + 3), 1'b0, 1'b0, 7'h31, 6'd21);
        step();
        drive_enq(4'h4, 12'h003, 7'h12, 1'b1, 1'b0, 7'h32, 6'd22);
        step();
        iq_enq_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            checks++; if (issue_valid !== 1'b0 || PRF_req_A_valid !== 1'b0) begin errors++; $display("FAIL stall_hold%0d: got v%0b prf %0b exp 0 0", c, issue_valid, PRF_req_A_valid); end
            step();
        end
        issue_ready = 1'b1;
        settle();
        checks++; if (issue_valid !== 1'b1 || issue_ROB_index !== 6'd20) begin errors++; $display("FAIL stall_first: got v%0b rob %0d exp v1 rob 20", issue_valid, issue_ROB_index); end
        step();
        settle();
        checks++; if (issue_valid !== 1'b1 || issue_ROB_index !== 6'd22) begin errors++; $display("FAIL stall_second: got v%0b rob %0d exp v1 rob 22", issue_valid, issue_ROB_index); end
        step();
        settle();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL stall_waiting: got %0b exp 0", issue_valid); end
        WB_bus_valid_by_bank       = 4'b1000;
        WB_bus_upper_PR_by_bank[3] = 5'd20;
        settle();
        checks++; if (issue_valid !== 1'b1 || issue_ROB_index !== 6'd21 || issue_A_forward !== 1'b1) begin errors++; $display("FAIL stall_third: got v%0b rob %0d fwd %0b exp v1 rob 21 fwd 1", issue_valid, issue_ROB_index, issue_A_forward); end
        step();
        idle_inputs();
    endtask

    task automatic test_zero();
        drive_enq(4'h5, 12'hABC, 7'h00, 1'b0, 1'b1, 7'h33, 6'd12);
        settle();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL zero_same_cycle: got %0b exp 0", issue_valid); end
        step();
        idle_inputs();
        settle();
        checks++; if (issue_valid !== 1'b1 || issue_A_is_zero !== 1'b1) begin errors++; $display("FAIL zero_issue: got v%0b z%0b exp v1 z1", issue_valid, issue_A_is_zero); end
        checks++; if (PRF_req_A_valid !== 1'b0 || issue_A_forward !== 1'b0) begin errors++; $display("FAIL zero_srcs: got prf %0b fwd %0b exp 0 0", PRF_req_A_valid, issue_A_forward); end
        step();
    endtask

    task automatic test_back_to_back();
        drive_enq(4'h6, 12'h010, 7'h14, 1'b1, 1'b0, 7'h40, 6'd30);
        step();
        drive_enq(4'h7, 12'h020, 7'h18, 1'b1, 1'b0, 7'h41, 6'd31);
        settle();
        checks++; if (issue_valid !== 1'b1 || issue_ROB_index !== 6'd30) begin errors++; $display("FAIL b2b_first: got v%0b rob %0d exp v1 rob 30", issue_valid, issue_ROB_index); end
`ifdef ALU_IMM_IQ_OCCUPANCY_EN
        checks++; if (iq_occupancy !== 4'd1) begin errors++; $display("FAIL b2b_occ: got %0d exp 1", iq_occupancy); end
`endif
        step();
        idle_inputs();
        settle();
        checks++; if (issue_valid !== 1'b1 || issue_ROB_index !== 6'd31 || issue_op !== 4'h7) begin errors++; $display("FAIL b2b_second: got v%0b rob %0d op %h exp v1 rob 31 op 7", issue_valid, issue_ROB_index, issue_op); end
        step();
        settle();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %0b exp 0", issue_valid); end
    endtask

    // Five waiting entries on bank 0, tags 24..28, then a reset mid-flight.
    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) begin
            drive_enq(4'h8, 12'(i), 7'((24 + i) * 4), 1'b0, 1'b0, 7'(i), 6'(40 + i));
            step();
        end
        idle_inputs();
        settle();
`ifdef ALU_IMM_IQ_OCCUPANCY_EN
        checks++; if (iq_occupancy !== 4'd5) begin errors++; $display("FAIL mrst_occ_before: got %0d exp 5", iq_occupancy); end
`endif
        nRST = 1'b0;
        step();
        nRST = 1'b1;
        settle();
        checks++; if (iq_enq_ready !== 1'b1 || issue_valid !== 1'b0) begin errors++; $display("FAIL mrst_state: got rdy %0b v %0b exp 1 0", iq_enq_ready, issue_valid); end
`ifdef ALU_IMM_IQ_OCCUPANCY_EN
        checks++; if (iq_occupancy !== 4'd0) begin errors++; $display("FAIL mrst_occ: got %0d exp 0", iq_occupancy); end
`endif
        WB_bus_valid_by_bank       = 4'b0001;
        WB_bus_upper_PR_by_bank[0] = 5'd24;
        settle();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL mrst_cleared: got %0b exp 0", issue_valid); end
        step();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_prf_issue();
        test_forward();
        test_fill();
        test_stall();
        test_zero();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_imm_iq.md
Name: alu_imm_iq

Overview:
- ALU reg-imm issue queue. Receiving end of the dispatch-queue → issue-queue enqueue handshake (iq_enq_*).
- Holds up to ALU_IMM_IQ_ENTRIES ops, oldest at entry 0, and snoops the per-bank writeback bus to wake up operand A.
- Each cycle issues the oldest ready op to the ALU reg-imm pipeline.
- Issue either requests A from the PRF or flags a writeback-bus forward.

Parameters:
- ALU_IMM_IQ_ENTRIES, 8, queue depth (≥2).

Ports:
- CLK  in  1  clock.
- nRST  in  1  synchronous active-low reset.
- iq_enq_valid  in  1  enqueue request.
- iq_enq_op  in  4  ALU op.
- iq_enq_imm12  in  12  immediate.
- iq_enq_A_PR  in  PR_t  source A physical register.
- iq_enq_A_ready  in  1  A already written.
- iq_enq_A_is_zero  in  1  A is x0.
- iq_enq_dest_PR  in  PR_t  destination.
- iq_enq_ROB_index  in  ROB_index_t  ROB tag.
- iq_enq_ready  out  1  queue can accept.
- WB_bus_valid_by_bank  in  PRF_BANK_COUNT  writeback valid per bank.
- WB_bus_upper_PR_by_bank  in  PRF_BANK_COUNT×upper_PR_t  writeback tag per bank.
- issue_valid  out  1  op issued this cycle.
- issue_op  out  4  issued op.
- issue_imm12  out  12  issued immediate.
- issue_A_forward  out  1  take A from WB bus (bank issue_A_bank).
- issue_A_is_zero  out  1  A reads as zero.
- issue_A_bank  out  bank bits  bank of A.
- issue_dest_PR  out  PR_t  destination.
- issue_ROB_index  out  ROB_index_t  ROB tag.
- PRF_req_A_valid  out  1  PRF read request for A.
- PRF_req_A_PR  out  PR_t  PR to read.
- issue_ready  in  1  pipeline can accept.

Behaviour:
- Clock and reset: one clock CLK. Reset nRST is synchronous and active-low: on a CLK edge with nRST=0, all valid bits clear and all entry fields clear.
- Reset output values: all outputs 0, except iq_enq_ready=1.

Wakeup:
- new_A_ready[i] = valid[i] & WB_bus_valid_by_bank[bank(A_PR[i])] & (upper(A_PR[i]) == WB_bus_upper_PR_by_bank[bank(A_PR[i])]).
- Bank and upper slices come from core_types::PR_bank_bits and core_types::upper_PR_bits.
- A stored entry's A_ready becomes A_ready | new_A_ready at every edge.

Ready and select:
- Entry i is ready when valid & (A_ready | A_is_zero | new_A_ready).
- Select is the lowest-index ready entry (pe_lsb).
- issuing = any ready & issue_ready.

Issue outputs:
- issue_valid = issuing. All fields are combinational from the selected entry.
- issue_A_forward = new_A_ready & ~A_ready & ~A_is_zero.
- PRF_req_A_valid = issuing & A_ready & ~A_is_zero.
- A_is_zero ops request neither PRF nor forward.
- Exactly one of {forward, PRF request, is_zero} is true on an issue.

Enqueue:
- iq_enq_ready = ~valid[ENTRIES-1], registered-state only. It does not depend on same-cycle issue.
- Enqueue occurs when iq_enq_valid & iq_enq_ready.
- Stored A_ready = iq_enq_A_ready | WB match on iq_enq_A_PR in the same cycle.
- An op enqueued this cycle cannot issue this cycle; earliest issue is the next cycle (1-cycle minimum latency).

Compaction:
- Issued index k: entries < k hold; entries > k shift down one, carrying A_ready | new_A_ready.
- The enqueue is written at index (count − issuing), so the queue stays contiguous from entry 0 and in age order.
- Full with issue in the same cycle: no enqueue (ready=0); top entry becomes invalid.
- Empty: issue_valid=0, PRF_req_A_valid=0.
- issue_ready=0: no state shift; wakeup still accumulates.

Optional Feature:
- Macro: ALU_IMM_IQ_OCCUPANCY_EN.
- Defined: adds output iq_occupancy, width $clog2(ALU_IMM_IQ_ENTRIES+1).
  - It is a registered count: +1 on enqueue, −1 on issue, unchanged when both happen.
  - Reset value is 0.
  - It always equals popcount(valid).
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- core_types supplies PR_t, upper_PR_t, ROB_index_t, PRF_BANK_COUNT, PR_bank_bits(), upper_PR_bits().
- Add an alu_imm_iq_entry_t struct (op, imm12, A_PR, A_ready, A_is_zero, dest_PR, ROB_index) to core_types.
- Existing pe_lsb is reused for select.
- One natural sub-module: alu_imm_iq_wakeup, a per-entry WB tag compare producing new_A_ready.

Test Plan:
- Reset then enqueue op=4'h2, imm=12'h0FF, A_ready=1, issue_ready=1 → next cycle issue_valid=1, PRF_req_A_valid=1, PRF_req_A_PR=A_PR, issue_A_forward=0.
- Enqueue A_ready=0 with A_PR in bank 1. Two cycles later, WB_bus_valid_by_bank[1]=1 with a matching upper tag → issue in that same cycle with issue_A_forward=1, issue_A_bank=1, PRF_req_A_valid=0.
- Fill 8 entries (ROB 0..7), all not ready → iq_enq_ready=0. Wake entry 3 → ROB 3 issues; entries then hold ROB 0,1,2,4,5,6,7 in order; iq_enq_ready=1 next cycle.
- Entries 0 and 2 ready, issue_ready=0 for 3 cycles, then 1 → ROB of entry 0 issues first, entry 2 next cycle; no ops lost.
- A_is_zero=1, A_ready=0 → issues next cycle with issue_A_is_zero=1, no PRF request, no forward.
- nRST=0 held one edge while 5 entries are valid → all valid bits clear, iq_enq_ready=1, issue_valid=0; with OCCUPANCY_EN, iq_occupancy=0.
